// File: rtl/spi_reg_burst.sv
// SPI target with burst read/write access to a register bank, runtime-selectable SPI mode,
// status poll, fast commands and frame error reporting. Fully synchronous to clk.
module spi_reg_burst #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned REG_W       = 16,
  parameter int unsigned NUM_REGS    = 48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic              reg_rd_stb,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_wr_stb,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld,
  output logic              frame_err
);

  localparam int unsigned        CNT_W      = $clog2(REG_W);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(REG_W - 1);
  localparam logic [CNT_W-1:0]   CMD_LAST   = CNT_W'(7);
  localparam logic [ADDR_W:0]    NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {StWaitDesel, StIdle, StCmd, StData} state_e;
  typedef enum logic [1:0] {OpRead = 2'b00, OpStatus = 2'b01, OpWrite = 2'b10,
                            OpFast = 2'b11} op_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_nss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sclk_sync <= '0;
      r_nss_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  state_e             r_state;
  op_e                r_op;
  logic               r_cpol;
  logic               r_cpha;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [REG_W-2:0]   r_isr;
  logic [REG_W-1:0]   r_osr;
  logic               r_err;
  logic               r_shift_pend;
  logic               r_bnd_pend;
  logic               r_ld_req;
  logic [ADDR_W-1:0]  r_reg_addr;
  logic               r_rd_stb;
  logic [REG_W-1:0]   r_data_o;
  logic               r_wr_stb;
  logic [5:0]         r_fastcmd;
  logic               r_fastcmd_vld;
  logic               r_frame_err;

  logic               w_sclk;
  logic               w_nss;
  logic               w_mosi;
  logic               w_rise;
  logic               w_fall;
  logic               w_lead;
  logic               w_trail;
  logic               w_sample;
  logic               w_change;
  logic [7:0]         w_byte_in;
  logic [REG_W-1:0]   w_word_in;
  logic [ADDR_W-1:0]  w_cmd_addr;
  logic               w_cmd_err;
  logic [ADDR_W-1:0]  w_addr_inc;
  logic [REG_W-1:0]   w_status_word;
  logic               w_desel;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_cmd_done;
  logic               w_word_done;
  logic               w_byte_bnd;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
  assign w_nss   = r_nss_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise  = w_sclk & ~r_sclk_d;
  assign w_fall  = ~w_sclk & r_sclk_d;
  assign w_lead  = r_cpol ? w_fall : w_rise;
  assign w_trail = r_cpol ? w_rise : w_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_change = r_cpha ? w_lead : w_trail;

  assign w_byte_in     = {r_isr[6:0], w_mosi};
  assign w_word_in     = {r_isr, w_mosi};
  assign w_cmd_addr    = w_byte_in[ADDR_W-1:0];
  assign w_cmd_err     = {1'b0, w_cmd_addr} >= NUM_REGS_X;
  assign w_addr_inc    = (r_reg_addr == LAST_ADDR) ? '0 : r_reg_addr + ADDR_W'(1);
  assign w_status_word = REG_W'(status) << (REG_W - 8);
  assign w_desel       = ((r_state == StCmd) || (r_state == StData)) && w_nss;

  assign w_cnt_inc   = r_bit_cnt + CNT_W'(1);
  assign w_cmd_done  = (r_state == StCmd) && w_sample && (r_bit_cnt == CMD_LAST);
  assign w_word_done = (r_state == StData) && w_sample && (r_bit_cnt == LAST_BIT);
  assign w_byte_bnd  = (r_state == StData) && w_sample && (r_bit_cnt[2:0] == 3'd7);
  assign w_cnt_nxt   = (w_cmd_done || w_word_done) ? '0 : (w_sample ? w_cnt_inc : r_bit_cnt);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= StWaitDesel;
      r_op          <= OpRead;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_bit_cnt     <= '0;
      r_isr         <= '0;
      r_osr         <= '0;
      r_err         <= 1'b0;
      r_shift_pend  <= 1'b0;
      r_bnd_pend    <= 1'b0;
      r_ld_req      <= 1'b0;
      r_reg_addr    <= '0;
      r_rd_stb      <= 1'b0;
      r_data_o      <= '0;
      r_wr_stb      <= 1'b0;
      r_fastcmd     <= '0;
      r_fastcmd_vld <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rd_stb      <= 1'b0;
      r_wr_stb      <= 1'b0;
      r_fastcmd_vld <= 1'b0;
      r_frame_err   <= 1'b0;
      r_ld_req      <= 1'b0;

      // Strobe follow-ups run outside the state decode so a word finishing on deselect completes.
      if (r_wr_stb) begin
        r_reg_addr <= w_addr_inc;
      end
      if (r_ld_req) begin
        r_osr      <= r_err ? '0 : reg_data_i;
        r_reg_addr <= w_addr_inc;
      end

      case (r_state)
        StWaitDesel: begin
          if (w_nss) begin
            r_state <= StIdle;
          end
        end
        StIdle: begin
          if (!w_nss) begin
            r_cpol       <= cpol;
            r_cpha       <= cpha;
            r_bit_cnt    <= '0;
            r_err        <= 1'b0;
            r_shift_pend <= 1'b0;
            r_bnd_pend   <= 1'b0;
            r_osr        <= w_status_word;
            r_state      <= StCmd;
          end
        end
        StCmd: begin
          if (w_sample) begin
            r_isr        <= w_word_in[REG_W-2:0];
            r_shift_pend <= 1'b1;
            r_bit_cnt    <= w_cnt_nxt;
          end else if (w_change && r_shift_pend) begin
            r_osr        <= r_osr << 1;
            r_shift_pend <= 1'b0;
          end
          if (w_cmd_done) begin
            if (w_byte_in[7:6] == OpFast) begin
              r_fastcmd     <= w_byte_in[5:0];
              r_fastcmd_vld <= 1'b1;
              r_osr         <= '0;
              r_state       <= StWaitDesel;
            end else begin
              r_op       <= op_e'(w_byte_in[7:6]);
              r_reg_addr <= w_cmd_addr;
              r_err      <= w_cmd_err;
              r_bnd_pend <= 1'b1;
              r_state    <= StData;
            end
          end
        end
        StData: begin
          if (w_sample) begin
            r_isr        <= w_word_in[REG_W-2:0];
            r_shift_pend <= 1'b1;
            r_bit_cnt    <= w_cnt_nxt;
            if (w_word_done && (r_op == OpWrite)) begin
              r_data_o <= w_word_in;
              r_wr_stb <= ~r_err;
            end
            // Status poll refreshes every byte so each byte on the wire carries the status.
            if (w_word_done || ((r_op == OpStatus) && w_byte_bnd)) begin
              r_bnd_pend <= 1'b1;
            end
          end else if (w_change && r_shift_pend) begin
            r_shift_pend <= 1'b0;
            r_bnd_pend   <= 1'b0;
            if (r_bnd_pend && (r_op == OpRead)) begin
              r_ld_req <= 1'b1;
              r_rd_stb <= ~r_err;
            end else if (r_bnd_pend && (r_op == OpStatus)) begin
              r_osr <= w_status_word;
            end else begin
              r_osr <= r_osr << 1;
            end
          end
        end
        default: r_state <= StWaitDesel;
      endcase

      if (w_desel) begin
        r_state     <= StIdle;
        r_frame_err <= (w_cnt_nxt != '0) || r_err;
        r_osr       <= '0;
      end
    end
  end

  assign miso        = r_osr[REG_W-1];
  assign miso_oe     = ~w_nss;
  assign reg_addr    = r_reg_addr;
  assign reg_rd_stb  = r_rd_stb;
  assign reg_data_o  = r_data_o;
  assign reg_wr_stb  = r_wr_stb;
  assign fastcmd     = r_fastcmd;
  assign fastcmd_vld = r_fastcmd_vld;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_reg_burst.sv
// Directed bench for spi_reg_burst: bit-banged SPI host, register-file model and event logs.
module tb_spi_reg_burst;

  localparam int HALF = 8;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        sclk = 1'b0;
  logic        nss  = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [5:0]  reg_addr;
  logic [15:0] reg_data_i;
  logic        reg_rd_stb;
  logic [15:0] reg_data_o;
  logic        reg_wr_stb;
  logic [7:0]  status = 8'h00;
  logic [5:0]  fastcmd;
  logic        fastcmd_vld;
  logic        frame_err;

  logic [15:0] mem [0:47];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          fe_cnt = 0;
  int          fc_cnt = 0;
  logic [5:0]  wr_addr_log [0:15];
  logic [15:0] wr_data_log [0:15];
  logic [5:0]  rd_addr_log [0:15];
  logic        cur_pol = 1'b0;
  logic        cur_pha = 1'b0;

  always #5 clk = ~clk;

  // Unimplemented addresses return a non-zero pattern so error masking is visible.
  assign reg_data_i = (reg_addr < 6'd48) ? mem[reg_addr] : 16'hDEAD;

  spi_reg_burst #(
    .ADDR_W     (6),
    .REG_W      (16),
    .NUM_REGS   (48),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cpol       (cpol),
    .cpha       (cpha),
    .sclk       (sclk),
    .nss        (nss),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .reg_addr   (reg_addr),
    .reg_data_i (reg_data_i),
    .reg_rd_stb (reg_rd_stb),
    .reg_data_o (reg_data_o),
    .reg_wr_stb (reg_wr_stb),
    .status     (status),
    .fastcmd    (fastcmd),
    .fastcmd_vld(fastcmd_vld),
    .frame_err  (frame_err)
  );

  always @(posedge clk) begin
    if (reg_wr_stb) begin
      wr_addr_log[wr_cnt % 16] <= reg_addr;
      wr_data_log[wr_cnt % 16] <= reg_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_rd_stb) begin
      rd_addr_log[rd_cnt % 16] <= reg_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (fastcmd_vld) fc_cnt <= fc_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_start(input logic pol, input logic pha);
    cur_pol = pol;
    cur_pha = pha;
    cpol    = pol;
    cpha    = pha;
    sclk    = pol;
    tick(12);
    nss = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_bits(input int n, input logic [63:0] tx, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cur_pha) begin
        mosi = tx[i];
        tick(HALF);
        sclk  = ~cur_pol;
        rx[i] = miso;
        tick(HALF);
        sclk = cur_pol;
      end else begin
        sclk = ~cur_pol;
        mosi = tx[i];
        tick(HALF);
        sclk  = cur_pol;
        rx[i] = miso;
        tick(HALF);
      end
    end
  endtask

  task automatic spi_stop();
    tick(HALF);
    nss  = 1'b1;
    mosi = 1'b0;
    tick(12);
  endtask

  logic [63:0] rx;
  int          w0;
  int          r0;
  int          f0;
  int          c0;

  initial begin
    for (int i = 0; i < 48; i++) mem[i] = 16'h1100 + 16'(i);
    mem[47] = 16'hA1B2;
    mem[0]  = 16'h0F0F;
    mem[1]  = 16'h8001;

    tick(4);
    check("rst_miso_oe", 64'(miso_oe), 64'd0);
    check("rst_outputs", 64'({miso, reg_addr, reg_rd_stb, reg_data_o, reg_wr_stb, fastcmd,
                              fastcmd_vld, frame_err}), 64'd0);
    nrst = 1'b1;
    tick(6);

    // Mode 0 burst write of two words starting at address 3.
    status = 8'hA5;
    w0 = wr_cnt; f0 = fe_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(40, 64'({8'h83, 16'hBEEF, 16'h1234}), rx);
    spi_stop();
    check("wr_status_byte", 64'(rx[39:32]), 64'hA5);
    check("wr_count", 64'(wr_cnt - w0), 64'd2);
    check("wr0_addr", 64'(wr_addr_log[w0 % 16]), 64'd3);
    check("wr0_data", 64'(wr_data_log[w0 % 16]), 64'hBEEF);
    check("wr1_addr", 64'(wr_addr_log[(w0 + 1) % 16]), 64'd4);
    check("wr1_data", 64'(wr_data_log[(w0 + 1) % 16]), 64'h1234);
    check("wr_no_ferr", 64'(fe_cnt - f0), 64'd0);
    check("wr_addr_after", 64'(reg_addr), 64'd5);

    // Mode 3 burst read wrapping from the last register.
    status = 8'h3C;
    r0 = rd_cnt; f0 = fe_cnt;
    spi_start(1'b1, 1'b1);
    spi_bits(56, 64'({8'h2F, 48'h0}), rx);
    spi_stop();
    check("rd_status_byte", 64'(rx[55:48]), 64'h3C);
    check("rd_data", 64'(rx[47:0]), 64'hA1B2_0F0F_8001);
    check("rd_count", 64'(rd_cnt - r0), 64'd3);
    check("rd0_addr", 64'(rd_addr_log[r0 % 16]), 64'd47);
    check("rd1_addr", 64'(rd_addr_log[(r0 + 1) % 16]), 64'd0);
    check("rd2_addr", 64'(rd_addr_log[(r0 + 2) % 16]), 64'd1);
    check("rd_no_ferr", 64'(fe_cnt - f0), 64'd0);

    // Out-of-range address: write suppressed, read returns zero, both flag a frame error.
    w0 = wr_cnt; f0 = fe_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(24, 64'({8'hB2, 16'h5555}), rx);
    spi_stop();
    check("badwr_no_write", 64'(wr_cnt - w0), 64'd0);
    check("badwr_ferr", 64'(fe_cnt - f0), 64'd1);
    f0 = fe_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(24, 64'({8'h32, 16'h0000}), rx);
    spi_stop();
    check("badrd_zero", 64'(rx[15:0]), 64'h0000);
    check("badrd_ferr", 64'(fe_cnt - f0), 64'd1);

    // Fast command followed by extra clocks.
    w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt; c0 = fc_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(24, 64'({8'hC7, 16'hFFFF}), rx);
    spi_stop();
    check("fast_code", 64'(fastcmd), 64'h07);
    check("fast_vld_count", 64'(fc_cnt - c0), 64'd1);
    check("fast_status_byte", 64'(rx[23:16]), 64'h3C);
    check("fast_miso_zero", 64'(rx[15:0]), 64'h0000);
    check("fast_no_strobes", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
    check("fast_no_ferr", 64'(fe_cnt - f0), 64'd0);

    // Status poll in mode 1, then a write in mode 2.
    status = 8'h5A;
    w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
    spi_start(1'b0, 1'b1);
    spi_bits(24, 64'({8'h40, 16'h0000}), rx);
    spi_stop();
    check("poll_bytes", 64'(rx[23:0]), 64'h5A5A5A);
    check("poll_no_strobes", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
    check("poll_no_ferr", 64'(fe_cnt - f0), 64'd0);
    status = 8'hC3;
    w0 = wr_cnt; f0 = fe_cnt;
    spi_start(1'b1, 1'b0);
    spi_bits(24, 64'({8'h85, 16'hCAFE}), rx);
    spi_stop();
    check("m2_status_byte", 64'(rx[23:16]), 64'hC3);
    check("m2_wr_count", 64'(wr_cnt - w0), 64'd1);
    check("m2_wr_addr", 64'(wr_addr_log[w0 % 16]), 64'd5);
    check("m2_wr_data", 64'(wr_data_log[w0 % 16]), 64'hCAFE);
    check("m2_no_ferr", 64'(fe_cnt - f0), 64'd0);

    // Partial write word: 8 command bits plus 3 data bits.
    w0 = wr_cnt; f0 = fe_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(11, 64'({8'h86, 3'b101}), rx);
    spi_stop();
    check("part_no_write", 64'(wr_cnt - w0), 64'd0);
    check("part_ferr", 64'(fe_cnt - f0), 64'd1);

    // Reset in the middle of a frame, remaining clocks ignored, then a clean frame.
    spi_start(1'b0, 1'b0);
    spi_bits(12, 64'({8'h87, 4'hA}), rx);
    nrst = 1'b0;
    tick(3);
    check("midrst_miso_oe", 64'(miso_oe), 64'd0);
    check("midrst_outputs", 64'({miso, reg_addr, reg_rd_stb, reg_data_o, reg_wr_stb, fastcmd,
                                 fastcmd_vld, frame_err}), 64'd0);
    nrst = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
    tick(4);
    spi_bits(8, 64'hFF, rx);
    spi_stop();
    check("midrst_ignored", 64'((wr_cnt - w0) + (rd_cnt - r0) + (fe_cnt - f0)), 64'd0);
    w0 = wr_cnt; f0 = fe_cnt;
    spi_start(1'b0, 1'b0);
    spi_bits(24, 64'({8'h88, 16'h7E81}), rx);
    spi_stop();
    check("post_wr_count", 64'(wr_cnt - w0), 64'd1);
    check("post_wr_addr", 64'(wr_addr_log[w0 % 16]), 64'd8);
    check("post_wr_data", 64'(wr_data_log[w0 % 16]), 64'h7E81);
    check("post_no_ferr", 64'(fe_cnt - f0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
